// File: rtl/riscv_def.sv
// Shared definitions for the CSR arbitration path.
// Holds CSR decode constants and the arbiter state encoding.
package riscv_def;

    localparam logic [31:0] INST_CSR_MASK  = 32'h0000_007f;
    localparam logic [31:0] INST_CSR_MATCH = 32'h0000_0073;

    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;
    localparam logic [2:0] F3_CSRWI = 3'b101;
    localparam logic [2:0] F3_CSRSI = 3'b110;
    localparam logic [2:0] F3_CSRCI = 3'b111;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        EXEC        = 2'd1,
        WAIT_COMMIT = 2'd2,
        WB          = 2'd3
    } csr_state_t;

endpackage

// File: rtl/riscv_csr_decode.sv
// Per-lane CSR instruction decode.
// Flags set/clear forms whose source is x0 / zimm 0 as write-free.
module riscv_csr_decode
    import riscv_def::*;
(
    input  logic [31:0] inst,
    output logic        is_csr,
    output logic        is_imm,
    output logic        write_suppress,
    output logic [4:0]  rd,
    output logic [11:0] csr_addr
);

    logic [2:0] f3;
    logic       opc_hit;

    assign f3       = inst[14:12];
    assign opc_hit  = (inst & INST_CSR_MASK) == INST_CSR_MATCH;
    assign is_csr   = opc_hit && (f3 != F3_PRIV);
    assign is_imm   = f3[2];
    assign rd       = inst[11:7];
    assign csr_addr = inst[31:20];

    assign write_suppress = is_csr && f3[1] && (inst[19:15] == 5'd0);

endmodule

// File: rtl/riscv_csr_arbiter.sv
// Dual-lane CSR arbiter: grants one CSR op at a time, holds its
// write until commit, and drops it on flush.
module riscv_csr_arbiter
    import riscv_def::*;
#(
    parameter bit HOLD_UNTIL_COMMIT = 1'b1
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        lane0_valid,
    input  logic [31:0] lane0_inst,
    input  logic [31:0] lane0_ra_data,
    input  logic        lane1_valid,
    input  logic [31:0] lane1_inst,
    input  logic [31:0] lane1_ra_data,
    output logic        lane0_ready,
    output logic        lane1_ready,
    output logic        csr_inst_valid,
    output logic [31:0] csr_inst,
    output logic [4:0]  csr_ra_idx,
    output logic [31:0] csr_ra_data,
    input  logic        csr_result_write,
    input  logic [31:0] csr_result_wdata,
    input  logic [31:0] csr_result_rdata,
    output logic        csr_writeback_write,
    output logic [11:0] csr_writeback_waddr,
    output logic [31:0] csr_writeback_wdata,
    output logic        res_valid,
    output logic        res_lane,
    output logic [4:0]  res_rd,
    output logic [31:0] res_rdata,
    input  logic        csr_commit,
    input  logic        flush,
    output logic        csr_busy
);

    csr_state_t state;

    logic        csr0, imm0, sup0;
    logic        csr1, imm1, sup1;
    logic [4:0]  rd0, rd1;
    logic [11:0] addr0, addr1;

    riscv_csr_decode u_dec0 (
        .inst           (lane0_inst),
        .is_csr         (csr0),
        .is_imm         (imm0),
        .write_suppress (sup0),
        .rd             (rd0),
        .csr_addr       (addr0)
    );

    riscv_csr_decode u_dec1 (
        .inst           (lane1_inst),
        .is_csr         (csr1),
        .is_imm         (imm1),
        .write_suppress (sup1),
        .rd             (rd1),
        .csr_addr       (addr1)
    );

    logic idle_ok;
    logic gnt0, gnt1;

    assign idle_ok  = (state == IDLE) && !flush;
    assign csr_busy = (state != IDLE);

    assign lane0_ready = !lane0_valid || !csr0 || idle_ok;
    assign lane1_ready = lane0_ready &&
        (!lane1_valid || !csr1 ||
         (idle_ok && !(lane0_valid && csr0)));

    assign gnt0 = lane0_valid && csr0 && lane0_ready;
    assign gnt1 = lane1_valid && csr1 && lane1_ready;

    // Immediate forms hand zimm to the handler in place of rs1.
    always_comb begin
        csr_inst_valid = 1'b0;
        csr_inst       = '0;
        csr_ra_idx     = '0;
        csr_ra_data    = '0;
        if (gnt0) begin
            csr_inst_valid = 1'b1;
            csr_inst       = lane0_inst;
            csr_ra_idx     = lane0_inst[19:15];
            csr_ra_data    = imm0 ? {27'd0, lane0_inst[19:15]}
                                  : lane0_ra_data;
        end else if (gnt1) begin
            csr_inst_valid = 1'b1;
            csr_inst       = lane1_inst;
            csr_ra_idx     = lane1_inst[19:15];
            csr_ra_data    = imm1 ? {27'd0, lane1_inst[19:15]}
                                  : lane1_ra_data;
        end
    end

    logic        lane_q;
    logic        sup_q;
    logic [4:0]  rd_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state               <= IDLE;
            lane_q              <= 1'b0;
            sup_q               <= 1'b0;
            rd_q                <= '0;
            addr_q              <= '0;
            wdata_q             <= '0;
            res_valid           <= 1'b0;
            res_lane            <= 1'b0;
            res_rd              <= '0;
            res_rdata           <= '0;
            csr_writeback_write <= 1'b0;
            csr_writeback_waddr <= '0;
            csr_writeback_wdata <= '0;
        end else begin
            res_valid           <= 1'b0;
            res_lane            <= 1'b0;
            res_rd              <= '0;
            res_rdata           <= '0;
            csr_writeback_write <= 1'b0;
            csr_writeback_waddr <= '0;
            csr_writeback_wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        lane_q <= !gnt0;
                        rd_q   <= gnt0 ? rd0 : rd1;
                        addr_q <= gnt0 ? addr0 : addr1;
                        sup_q  <= gnt0 ? sup0 : sup1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (rd_q != 5'd0) begin
                            res_valid <= 1'b1;
                            res_lane  <= lane_q;
                            res_rd    <= rd_q;
                            res_rdata <= csr_result_rdata;
                        end
                        wdata_q <= csr_result_wdata;
                        // Without commit hold, the wait state passes
                        // straight through to WB on its next cycle.
                        if (csr_result_write && !sup_q)
                            state <= WAIT_COMMIT;
                        else
                            state <= IDLE;
                    end
                end
                WAIT_COMMIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (csr_commit || !HOLD_UNTIL_COMMIT) begin
                        state               <= WB;
                        csr_writeback_write <= 1'b1;
                        csr_writeback_waddr <= addr_q;
                        csr_writeback_wdata <= wdata_q;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/riscv_csr_arbiter.md
Name: riscv_csr_arbiter

Overview:
Shares the single CSR handler between the two issue lanes of the dual-issue in-order core. Each cycle it grants at most one CSR instruction and stalls the other lane so program order is kept. It captures the handler's one-cycle-later result and holds the CSR write until the instruction commits. The write is then sent to the handler's writeback port, or dropped if the instruction is flushed. While any CSR access is in flight, every further CSR instruction is held off, so the CSR space is never read while a write to it is still pending.

Parameters:
HOLD_UNTIL_COMMIT, 1, 1: the CSR write waits for csr_commit; 0: the write is issued the cycle after EXEC with no commit wait.

Ports:
clk  input  1  clock
srst_n  input  1  synchronous active-low reset
lane0_valid  input  1  lane0 (older) instruction valid
lane0_inst  input  32  lane0 instruction word
lane0_ra_data  input  32  lane0 rs1 value
lane1_valid  input  1  lane1 (younger) instruction valid
lane1_inst  input  32  lane1 instruction word
lane1_ra_data  input  32  lane1 rs1 value
lane0_ready  output  1  lane0 instruction accepted this cycle
lane1_ready  output  1  lane1 instruction accepted this cycle
csr_inst_valid  output  1  to handler inst_valid
csr_inst  output  32  to handler inst
csr_ra_idx  output  5  to handler ra_idx (inst[19:15])
csr_ra_data  output  32  to handler ra_data
csr_result_write  input  1  from handler
csr_result_wdata  input  32  from handler
csr_result_rdata  input  32  from handler
csr_writeback_write  output  1  to handler writeback write enable
csr_writeback_waddr  output  12  to handler writeback address
csr_writeback_wdata  output  32  to handler writeback data
res_valid  output  1  CSR read result valid
res_lane  output  1  lane that issued the result
res_rd  output  5  destination register
res_rdata  output  32  old CSR value for rd
csr_commit  input  1  the in-flight CSR instruction retired
flush  input  1  pipeline flush; kills the in-flight CSR access
csr_busy  output  1  FSM not IDLE

Behaviour:
- Reset is synchronous and active-low (srst_n) on clk. Reset values: FSM in IDLE; all outputs 0, except lane0_ready/lane1_ready, which follow the combinational rules below.
- Decode: a CSR instruction is opcode 1110011 with funct3 not equal to 000. Non-CSR instructions need no grant.
- Ready rules (combinational):
  - lane0_ready = !lane0_valid | !csr0 | (IDLE & !flush).
  - lane1_ready = lane0_ready & (!lane1_valid | !csr1 | (IDLE & !flush & !(lane0_valid & csr0))).
  - When both lanes hold CSR instructions, lane0 wins and lane1 stalls until it reaches IDLE again.
- Grant (cycle T): in IDLE with no flush, grant the oldest valid CSR instruction.
  - Drive csr_inst_valid=1 and csr_inst/csr_ra_idx/csr_ra_data from that lane for exactly one cycle.
  - Latch lane, rd (inst[11:7]), CSR address (inst[31:20]) and the write-suppress flag.
  - Go to EXEC.
  - Outside the grant cycle csr_inst_valid=0 and csr_inst/csr_ra_idx/csr_ra_data are 0.
- Write suppress: csrrs/csrrc with rs1 index 0, and csrrsi/csrrci with zimm 0, perform no CSR write.
- EXEC (cycle T+1):
  - Register res_valid=1 (visible at T+2 for one cycle) with res_rdata=csr_result_rdata, plus the latched res_lane and res_rd.
  - res_valid is not asserted when rd=0.
  - Latch wen = csr_result_write & !suppress, and wdata = csr_result_wdata.
  - If wen=0, go to IDLE.
  - Else if HOLD_UNTIL_COMMIT=0, go to WB.
  - Else go to WAIT_COMMIT.
- WAIT_COMMIT: on csr_commit, go to WB. Flush takes priority over csr_commit in the same cycle.
- WB:
  - Registered outputs csr_writeback_write=1, waddr=latched address, wdata=latched data, held for exactly one cycle.
  - Then go to IDLE.
  - A new grant is possible in the cycle after the WB cycle.
- Flush in EXEC or WAIT_COMMIT: go to IDLE, drop the pending write, and suppress res_valid.
  - Flush in WB has no effect: the write completes.
  - Flush in IDLE blocks that cycle's grant.
- csr_commit outside WAIT_COMMIT is ignored.
- Reset mid-operation: return to IDLE, no writeback emitted.
- Latency: grant to writeback is 3 cycles minimum with HOLD_UNTIL_COMMIT=0. Back-to-back CSR instructions are spaced 4 cycles with writes, or 2 cycles with no write.

Decomposition:
- Shared package (riscv_def): CSR opcode/funct3 constants (reuse the existing INST_CSR* mask/match macros) and the FSM state encodings IDLE/EXEC/WAIT_COMMIT/WB.
- One natural sub-module: riscv_csr_decode, a combinational block that takes one instruction word and produces is_csr, is_imm, write_suppress, rd and csr_addr. It is instantiated once per lane.

Test Plan:
- Single csrrw mscratch(0x340), rs1=0x1234 on lane0, rd=5, then commit at T+4 -> lane0_ready=1 at T; res_valid at T+2 with res_rd=5 and the old value; csr_writeback_write at T+5 with waddr=0x340, wdata=0x1234.
- Both lanes CSR at T (lane0 csrrs, lane1 csrrc) -> lane1_ready=0 until IDLE returns; lane1 granted only after lane0's WB; both writebacks in program order.
- csrrs rd=3, rs1=x0 on misa (0x301) -> res_rdata = misa; no csr_writeback_write ever; FSM IDLE at T+2.
- csrrw in WAIT_COMMIT, flush asserted together with csr_commit -> no writeback; csr_busy=0 next cycle; a following CSR instruction is granted.
- Lane0 non-CSR, lane1 csrrwi zimm=7 rd=0 while busy -> lane0_ready=1, lane1_ready=0; once granted, csr_ra_data=0x7 path is used, res_valid stays 0 (rd=0), writeback wdata=0x7.
- HOLD_UNTIL_COMMIT=0 build: csrrw at T -> writeback at T+3 with csr_commit held low; srst_n low during EXEC -> no writeback, all outputs 0.
